multicycle_alu: RTL

//  Parametrised, registered ALU for the multi-cycle MIPS datapath. Same opcode map as the

---
 rtl/multicycle_alu_if.sv | 25 ++
 rtl/multicycle_alu.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu_if.sv
// Handshake/data bundle between the multi-cycle datapath control and the ALU.
// master: control side (drives start/operation/operands); slave: the ALU.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       operation;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero_flag;
    logic             busy;
    logic             done;

    modport master (
        output start, operation, input_a, input_b,
        input  result, result_hi, zero_flag, busy, done
    );

    modport slave (
        input  start, operation, input_a, input_b,
        output result, result_hi, zero_flag, busy, done
    );
endinterface

// File: rtl/multicycle_alu.sv
// Registered ALU for the multi-cycle MIPS datapath with start/done handshake.
// Single-cycle ops complete in one edge; mult is an iterative shift-add over
// WIDTH cycles producing a 2*WIDTH product on {result_hi, result}.
// Optional feature macro ALU_DIV_EN: opcode 111 becomes an iterative unsigned
// restoring divider (result = quotient, result_hi = remainder).
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// ITER  | iterative mult/div in progress, one bit per cycle
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_alu_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MULT = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
`ifdef ALU_DIV_EN
    localparam logic [2:0] OP_DIVU = 3'b111;
`endif

    typedef enum logic {IDLE, ITER} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // acc: product high word / partial remainder
    // mq : multiplier shifting out, product low word shifting in / dividend -> quotient
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mq_q        <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            done_q      <= 1'b0;
`ifdef ALU_DIV_EN
            div_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mq_q        <= mq_d;
            opnd_q      <= opnd_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            done_q      <= done_d;
`ifdef ALU_DIV_EN
            div_q       <= div_d;
`endif
        end
    end

    // Next-state, single-cycle results and one iteration step of mult/div
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        opnd_d      = opnd_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        done_d      = 1'b0;
`ifdef ALU_DIV_EN
        div_d       = div_q;
        // Restoring step: shift next dividend bit into the partial remainder.
        // With a zero divisor every step subtracts, giving all-ones quotient and
        // the dividend as remainder.
        div_shift   = {acc_q, mq_q[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, opnd_q});
        div_sub     = div_shift[WIDTH-1:0] - opnd_q;
`endif
        mul_sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    result_hi_d = '0;
                    done_d      = 1'b1;
                    case (bus.operation)
                        OP_AND:  result_d = bus.input_a & bus.input_b;
                        OP_OR:   result_d = bus.input_a | bus.input_b;
                        OP_ADD:  result_d = bus.input_a + bus.input_b;
                        OP_SUB:  result_d = bus.input_a - bus.input_b;
                        OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, (bus.input_a < bus.input_b)};
                        OP_MULT: begin
                            result_d    = result_q;
                            result_hi_d = result_hi_q;
                            done_d      = 1'b0;
                            acc_d       = '0;
                            mq_d        = bus.input_a;
                            opnd_d      = bus.input_b;
                            cnt_d       = CW'(WIDTH);
                            state_d     = ITER;
`ifdef ALU_DIV_EN
                            div_d       = 1'b0;
`endif
                        end
`ifdef ALU_DIV_EN
                        OP_DIVU: begin
                            result_d    = result_q;
                            result_hi_d = result_hi_q;
                            done_d      = 1'b0;
                            acc_d       = '0;
                            mq_d        = bus.input_a;
                            opnd_d      = bus.input_b;
                            cnt_d       = CW'(WIDTH);
                            state_d     = ITER;
                            div_d       = 1'b1;
                        end
`endif
                        default: result_d = '0;
                    endcase
                end
            end
            ITER: begin
                cnt_d = cnt_q - CW'(1);
`ifdef ALU_DIV_EN
                if (div_q) begin
                    acc_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
`else
                acc_d = mul_sum[WIDTH:1];
                mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
`endif
                // Last bit is processed on this edge, so publish directly
                if (cnt_q == CW'(1)) begin
                    result_d    = mq_d;
                    result_hi_d = acc_d;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.zero_flag = ~|result_q;
    assign bus.busy      = (state_q == ITER);
    assign bus.done      = done_q;
endmodule
